// File: rtl/rv32i_alu_arbiter.sv
// Purpose  : shares one combinational RV32I ALU between req0 (execute) and req1 (aux), RR or fixed priority.
// Latency  : operation accepted in cycle N -> registered result/flags on O_RSPx_* in cycle N+1.
// Backpress: one-entry response buffer; no request is accepted while it is full and not draining.
module rv32i_alu_arbiter #(
    parameter int PRIO_MODE = 0,
    parameter int MAX_WAIT  = 4
) (
    input  logic        I_CLK,
    input  logic        I_RSTN,
    input  logic        I_REQ0_VALID,
    output logic        O_REQ0_READY,
    input  logic [31:0] I_REQ0_OP_A,
    input  logic [31:0] I_REQ0_OP_B,
    input  logic [2:0]  I_REQ0_OP_TYPE,
    input  logic        I_REQ1_VALID,
    output logic        O_REQ1_READY,
    input  logic [31:0] I_REQ1_OP_A,
    input  logic [31:0] I_REQ1_OP_B,
    input  logic [2:0]  I_REQ1_OP_TYPE,
    output logic [31:0] O_ALU_OP_A,
    output logic [31:0] O_ALU_OP_B,
    output logic [2:0]  O_ALU_OP_TYPE,
    input  logic [31:0] I_ALU_RESULT,
    input  logic [3:0]  I_ALU_NZCV,
    output logic        O_RSP0_VALID,
    output logic        O_RSP1_VALID,
    input  logic        I_RSP0_READY,
    input  logic        I_RSP1_READY,
    output logic [31:0] O_RSP_RESULT,
    output logic [3:0]  O_RSP_NZCV
);

    // Starvation limit for req1 in fixed-priority mode, sized to the 4-bit wait counter.
    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    // Response buffer (the EMPTY/FULL bit is rsp_vld) plus arbitration history.
    logic        rsp_vld_q, rsp_vld_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_res_q, rsp_res_d;
    logic [3:0]  rsp_nzcv_q, rsp_nzcv_d;
    logic        lg_q, lg_d;
    logic [3:0]  wc_q, wc_d;

    logic        rsp_drain;
    logic        can_grant;
    logic        gnt0;
    logic        gnt1;
    logic        any_gnt;

    // Grant decision: a slot exists only if the buffer is empty or its owner is consuming it.
    always_comb begin
        rsp_drain = rsp_vld_q & (rsp_id_q ? I_RSP1_READY : I_RSP0_READY);
        can_grant = ~rsp_vld_q | rsp_drain;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        if (I_RSTN && can_grant) begin
            if (I_REQ0_VALID && I_REQ1_VALID) begin
                if (PRIO_MODE == 0) begin
                    // Alternate away from whoever won last.
                    gnt0 = lg_q;
                    gnt1 = ~lg_q;
                end else begin
                    // req0 wins ties until req1 has waited long enough.
                    gnt1 = (wc_q == WAIT_LIM);
                    gnt0 = (wc_q != WAIT_LIM);
                end
            end else begin
                gnt0 = I_REQ0_VALID;
                gnt1 = I_REQ1_VALID;
            end
        end
        any_gnt = gnt0 | gnt1;
    end

    // Next-state for buffer, last-grant pointer and req1 wait counter.
    always_comb begin
        rsp_vld_d  = rsp_vld_q & ~rsp_drain;
        rsp_id_d   = rsp_id_q;
        rsp_res_d  = rsp_res_q;
        rsp_nzcv_d = rsp_nzcv_q;
        lg_d       = lg_q;
        wc_d       = wc_q;
        // A new grant overwrites the slot; together with a drain this gives back-to-back responses.
        if (any_gnt) begin
            rsp_vld_d  = 1'b1;
            rsp_id_d   = gnt1;
            rsp_res_d  = I_ALU_RESULT;
            rsp_nzcv_d = I_ALU_NZCV;
            lg_d       = gnt1;
        end
        // Any cycle req1 is waiting and not served counts, even when no slot was available.
        if (!I_REQ1_VALID || gnt1) begin
            wc_d = 4'd0;
        end else if (wc_q < WAIT_LIM) begin
            wc_d = wc_q + 4'd1;
        end
    end

    // State registers with synchronous active-low reset; a pending response is dropped.
    always_ff @(posedge I_CLK) begin
        if (!I_RSTN) begin
            rsp_vld_q  <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_res_q  <= 32'd0;
            rsp_nzcv_q <= 4'd0;
            lg_q       <= 1'b1;
            wc_q       <= 4'd0;
        end else begin
            rsp_vld_q  <= rsp_vld_d;
            rsp_id_q   <= rsp_id_d;
            rsp_res_q  <= rsp_res_d;
            rsp_nzcv_q <= rsp_nzcv_d;
            lg_q       <= lg_d;
            wc_q       <= wc_d;
        end
    end

    // Output drive: ALU sees only the granted requester; everything reads zero during reset.
    always_comb begin
        O_REQ0_READY  = gnt0;
        O_REQ1_READY  = gnt1;
        O_ALU_OP_A    = 32'd0;
        O_ALU_OP_B    = 32'd0;
        O_ALU_OP_TYPE = 3'd0;
        if (gnt0) begin
            O_ALU_OP_A    = I_REQ0_OP_A;
            O_ALU_OP_B    = I_REQ0_OP_B;
            O_ALU_OP_TYPE = I_REQ0_OP_TYPE;
        end else if (gnt1) begin
            O_ALU_OP_A    = I_REQ1_OP_A;
            O_ALU_OP_B    = I_REQ1_OP_B;
            O_ALU_OP_TYPE = I_REQ1_OP_TYPE;
        end
        O_RSP0_VALID = I_RSTN & rsp_vld_q & ~rsp_id_q;
        O_RSP1_VALID = I_RSTN & rsp_vld_q & rsp_id_q;
        O_RSP_RESULT = I_RSTN ? rsp_res_q : 32'd0;
        O_RSP_NZCV   = I_RSTN ? rsp_nzcv_q : 4'd0;
    end

endmodule

// File: tb/tb_rv32i_alu_arbiter.sv
// Bench for rv32i_alu_arbiter: one round-robin and one fixed-priority instance share stimulus.
// A behavioural ALU closes the loop; a per-instance reference model is checked every cycle.
// Directed scenarios pin the model with literal expectations, then a randomized run follows.
module tb_rv32i_alu_arbiter;

    localparam int MAXW = 4;
    localparam logic [2:0] OP_ADD = 3'd0;

    logic        clk = 1'b0;
    logic        rstn;
    logic        v0, v1, r0, r1;
    logic [31:0] a0, b0, a1, b1;
    logic [2:0]  t0, t1;

    logic [1:0]  o_rdy0, o_rdy1, o_rv0, o_rv1;
    logic [31:0] o_aa   [2];
    logic [31:0] o_ab   [2];
    logic [2:0]  o_at   [2];
    logic [31:0] o_res  [2];
    logic [3:0]  o_nzcv [2];
    logic [35:0] alu_o  [2];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: one-entry response slot, last winner, req1 wait count.
    bit          m_full [2] = '{0, 0};
    bit          m_id   [2] = '{0, 0};
    logic [31:0] m_res  [2];
    logic [3:0]  m_f    [2];
    int          m_lg   [2] = '{1, 1};
    int          m_wc   [2] = '{0, 0};

    always #5 clk = ~clk;

    // Behavioural RV32I ALU: returns {N,Z,C,V, result}.
    function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] t);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        s = 33'd0;
        case (t)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                        v = (a[31] == b[31]) && (r[31] != a[31]); end
            3'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[31:0]; c = ~s[32];
                        v = (a[31] != b[31]) && (r[31] != a[31]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a << b[4:0];
            3'd6: r = a >> b[4:0];
            default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    assign alu_o[0] = alu_fn(o_aa[0], o_ab[0], o_at[0]);
    assign alu_o[1] = alu_fn(o_aa[1], o_ab[1], o_at[1]);

    rv32i_alu_arbiter #(.PRIO_MODE(0), .MAX_WAIT(MAXW)) u_rr (
        .I_CLK(clk), .I_RSTN(rstn),
        .I_REQ0_VALID(v0), .O_REQ0_READY(o_rdy0[0]),
        .I_REQ0_OP_A(a0), .I_REQ0_OP_B(b0), .I_REQ0_OP_TYPE(t0),
        .I_REQ1_VALID(v1), .O_REQ1_READY(o_rdy1[0]),
        .I_REQ1_OP_A(a1), .I_REQ1_OP_B(b1), .I_REQ1_OP_TYPE(t1),
        .O_ALU_OP_A(o_aa[0]), .O_ALU_OP_B(o_ab[0]), .O_ALU_OP_TYPE(o_at[0]),
        .I_ALU_RESULT(alu_o[0][31:0]), .I_ALU_NZCV(alu_o[0][35:32]),
        .O_RSP0_VALID(o_rv0[0]), .O_RSP1_VALID(o_rv1[0]),
        .I_RSP0_READY(r0), .I_RSP1_READY(r1),
        .O_RSP_RESULT(o_res[0]), .O_RSP_NZCV(o_nzcv[0])
    );

    rv32i_alu_arbiter #(.PRIO_MODE(1), .MAX_WAIT(MAXW)) u_fp (
        .I_CLK(clk), .I_RSTN(rstn),
        .I_REQ0_VALID(v0), .O_REQ0_READY(o_rdy0[1]),
        .I_REQ0_OP_A(a0), .I_REQ0_OP_B(b0), .I_REQ0_OP_TYPE(t0),
        .I_REQ1_VALID(v1), .O_REQ1_READY(o_rdy1[1]),
        .I_REQ1_OP_A(a1), .I_REQ1_OP_B(b1), .I_REQ1_OP_TYPE(t1),
        .O_ALU_OP_A(o_aa[1]), .O_ALU_OP_B(o_ab[1]), .O_ALU_OP_TYPE(o_at[1]),
        .I_ALU_RESULT(alu_o[1][31:0]), .I_ALU_NZCV(alu_o[1][35:32]),
        .O_RSP0_VALID(o_rv0[1]), .O_RSP1_VALID(o_rv1[1]),
        .I_RSP0_READY(r0), .I_RSP1_READY(r1),
        .O_RSP_RESULT(o_res[1]), .O_RSP_NZCV(o_nzcv[1])
    );

    task automatic chk(input string nm, input int inst, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, inst, got, exp, $time);
        end
    endtask

    // Model compare: evaluated on the falling edge, then advanced to what the next rising edge does.
    always @(negedge clk) begin
        int          g;
        bit          drain, can;
        logic [35:0] ex;
        logic [31:0] ea, eb;
        logic [2:0]  et;
        for (int k = 0; k < 2; k++) begin
            if (!rstn) begin
                chk("rst_rdy0", k, o_rdy0[k], 0);
                chk("rst_rdy1", k, o_rdy1[k], 0);
                chk("rst_alu_a", k, o_aa[k], 0);
                chk("rst_alu_b", k, o_ab[k], 0);
                chk("rst_alu_t", k, o_at[k], 0);
                chk("rst_rsp0_vld", k, o_rv0[k], 0);
                chk("rst_rsp1_vld", k, o_rv1[k], 0);
                chk("rst_result", k, o_res[k], 0);
                chk("rst_nzcv", k, o_nzcv[k], 0);
                m_full[k] = 0;
                m_id[k]   = 0;
                m_lg[k]   = 1;
                m_wc[k]   = 0;
            end else begin
                drain = m_full[k] && (m_id[k] ? r1 : r0);
                can   = !m_full[k] || drain;
                g = -1;
                if (v0 && v1) begin
                    if (k == 0) g = (m_lg[k] == 1) ? 0 : 1;
                    else        g = (m_wc[k] >= MAXW) ? 1 : 0;
                end else if (v0) begin
                    g = 0;
                end else if (v1) begin
                    g = 1;
                end
                if (!can) g = -1;
                ea = (g == 0) ? a0 : (g == 1) ? a1 : 32'd0;
                eb = (g == 0) ? b0 : (g == 1) ? b1 : 32'd0;
                et = (g == 0) ? t0 : (g == 1) ? t1 : 3'd0;
                chk("rdy0", k, o_rdy0[k], (g == 0));
                chk("rdy1", k, o_rdy1[k], (g == 1));
                chk("alu_a", k, o_aa[k], ea);
                chk("alu_b", k, o_ab[k], eb);
                chk("alu_t", k, o_at[k], et);
                chk("rsp0_vld", k, o_rv0[k], m_full[k] && !m_id[k]);
                chk("rsp1_vld", k, o_rv1[k], m_full[k] && m_id[k]);
                if (m_full[k]) begin
                    chk("rsp_result", k, o_res[k], m_res[k]);
                    chk("rsp_nzcv", k, o_nzcv[k], m_f[k]);
                end
                if (drain) m_full[k] = 0;
                if (g >= 0) begin
                    ex        = (g == 0) ? alu_fn(a0, b0, t0) : alu_fn(a1, b1, t1);
                    m_full[k] = 1;
                    m_id[k]   = (g == 1);
                    m_res[k]  = ex[31:0];
                    m_f[k]    = ex[35:32];
                    m_lg[k]   = g;
                end
                if (!v1 || g == 1) m_wc[k] = 0;
                else if (m_wc[k] < MAXW) m_wc[k]++;
            end
        end
    end

    task automatic set_req(input bit pv0, input bit pv1, input bit pr0, input bit pr1);
        v0 = pv0; v1 = pv1; r0 = pr0; r1 = pr1;
    endtask

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        next_cyc();
        next_cyc();
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        a0 = 0; b0 = 0; t0 = OP_ADD; a1 = 0; b1 = 0; t1 = OP_ADD;
        set_req(0, 0, 1, 1);
        next_cyc();
        next_cyc();
        rstn = 1'b1;

        // Single req0 ADD 5+3: accepted now, result 8 one cycle later.
        a0 = 32'd5; b0 = 32'd3; t0 = OP_ADD;
        set_req(1, 0, 1, 1);
        @(negedge clk);
        chk("t1_rdy0", 0, o_rdy0[0], 1);
        chk("t1_alu_a", 0, o_aa[0], 32'd5);
        next_cyc();
        set_req(0, 0, 1, 1);
        @(negedge clk);
        chk("t1_rsp0_vld", 0, o_rv0[0], 1);
        chk("t1_result", 0, o_res[0], 32'd8);
        chk("t1_nzcv", 0, o_nzcv[0], 4'b0000);
        chk("t1_result", 1, o_res[1], 32'd8);
        next_cyc();

        // Round-robin tie for four cycles: 0,1,0,1 with a response every cycle.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a0 = 32'(i + 10); b0 = 32'd1; a1 = 32'(i + 20); b1 = 32'd2;
            set_req(1, 1, 1, 1);
            @(negedge clk);
            chk("t2_rdy1", 0, o_rdy1[0], (i % 2));
            chk("t2_rdy0", 0, o_rdy0[0], ((i + 1) % 2));
            if (i > 0) chk("t2_rsp1_vld", 0, o_rv1[0], ((i - 1) % 2));
            next_cyc();
        end
        set_req(0, 0, 1, 1);
        @(negedge clk);
        chk("t2_last_rsp1", 0, o_rv1[0], 1);
        chk("t2_last_res", 0, o_res[0], 32'd25);
        next_cyc();

        // Stalled req0 response with wrong-owner ready asserted, then release.
        do_reset();
        a0 = 32'd100; b0 = 32'd23; t0 = OP_ADD;
        a1 = 32'd7;   b1 = 32'd9;  t1 = OP_ADD;
        set_req(1, 1, 0, 1);
        @(negedge clk);
        chk("t3_rdy0", 0, o_rdy0[0], 1);
        chk("t3_rdy0", 1, o_rdy0[1], 1);
        next_cyc();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk("t6_rdy1", k, o_rdy1[k], 0);
                chk("t3_rdy0", k, o_rdy0[k], 0);
                chk("t3_rsp0_vld", k, o_rv0[k], 1);
                chk("t3_result", k, o_res[k], 32'd123);
            end
            next_cyc();
        end
        set_req(1, 1, 1, 1);
        @(negedge clk);
        chk("t3_resume_rr", 0, o_rdy1[0], 1);
        chk("t3_resume_fp", 1, o_rdy1[1], 1);
        next_cyc();
        set_req(0, 0, 1, 1);
        @(negedge clk);
        chk("t3_rsp1_vld", 0, o_rv1[0], 1);
        chk("t3_rsp1_res", 0, o_res[0], 32'd16);
        next_cyc();

        // Fixed priority: req0 four times, req1 forced on the fifth, then req0 again.
        do_reset();
        set_req(1, 1, 1, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t4_rdy1", 1, o_rdy1[1], (i == 4));
            chk("t4_rdy0", 1, o_rdy0[1], (i != 4));
            next_cyc();
        end

        // Reset while a req1 response is held.
        do_reset();
        set_req(0, 1, 1, 0);
        @(negedge clk);
        chk("t5_rdy1", 0, o_rdy1[0], 1);
        next_cyc();
        set_req(1, 1, 1, 0);
        @(negedge clk);
        chk("t5_rsp1_vld", 0, o_rv1[0], 1);
        next_cyc();
        rstn = 1'b0;
        @(negedge clk);
        chk("t5_rst_rsp1", 0, o_rv1[0], 0);
        chk("t5_rst_rdy0", 0, o_rdy0[0], 0);
        next_cyc();
        rstn = 1'b1;
        set_req(1, 1, 1, 1);
        @(negedge clk);
        chk("t5_post_rsp1", 0, o_rv1[0], 0);
        chk("t5_post_tie", 0, o_rdy0[0], 1);
        next_cyc();

        // Randomized traffic, backpressure and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            a0 = $urandom; b0 = $urandom; t0 = 3'($urandom_range(0, 7));
            a1 = $urandom; b1 = $urandom; t1 = 3'($urandom_range(0, 7));
            set_req($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6);
            rstn = ($urandom_range(0, 199) != 0);
            next_cyc();
        end
        rstn = 1'b1;
        set_req(0, 0, 1, 1);
        next_cyc();
        next_cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
